eva_ahb_timer_slave: RTL

AHB-lite slave sitting directly downstream of the EVA bus-functional AHB master. It decodes word accesses into a small register bank that holds an ID, control, reload and scratch values, and it runs a 32-bit down-counter timer. Its `intr` output feeds the EVA interrupt monitor, so the software side can exercise register access, error responses, wait states and interrupt delivery against one synthesizable target.

---
 rtl/eva_ahb_timer_slave_if.sv | 21 ++
 rtl/eva_ahb_timer_slave.sv | 111 +++++++++++
 2 files changed

// File: rtl/eva_ahb_timer_slave_if.sv
// eva_ahb_timer_slave_if: AHB-lite signal bundle between the EVA master and the timer slave.
interface eva_ahb_timer_slave_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    modport master (
        output hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
        input  hready_out, hresp, hrdata
    );
    modport slave (
        input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
        output hready_out, hresp, hrdata
    );
endinterface

// File: rtl/eva_ahb_timer_slave.sv
// eva_ahb_timer_slave: AHB-lite register slave with a 32-bit down-counter timer and level interrupt.
// Define EVA_AHB_WAIT_EN to insert WAIT_CYC wait states into every OKAY data phase.
module eva_ahb_timer_slave #(
    parameter logic [31:0] ID_VAL   = 32'hE7A0_0001,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic                  hclk,
    input  logic                  hrest_n,
    eva_ahb_timer_slave_if.slave  bus,
    output logic                  intr
);
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
    state_t      state;
    logic        wr;
    logic [3:0]  idx;
    logic [2:0]  ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic [31:0] scratch;
    logic        expd;
    logic        acc;
    logic        bad;
    logic        done;
    logic        ld_wr;
    logic        w1c;
    logic        tick;
    logic        fire;
    logic [31:0] rmux;
    logic        unused_bits;

    if (WAIT_CYC > 7) begin : g_wait_range
        $error("WAIT_CYC must be in 0..7");
    end

    assign unused_bits = ^{bus.haddr[31:6], bus.haddr[1:0]};
    assign acc   = bus.hsel & bus.htrans[1] & bus.hready_in;
    assign bad   = (bus.haddr[5:2] > 4'd5) | (bus.hsize != 3'b010) |
                   (bus.hwrite & (bus.haddr[5:2] == 4'd0 | bus.haddr[5:2] == 4'd3));
    assign done  = (state == DATA) & bus.hready_out;
    assign ld_wr = done & wr & (idx == 4'd2);
    assign w1c   = done & wr & (idx == 4'd4) & bus.hwdata[0];
    // A LOAD write pre-empts the decrement and any expiry in that cycle
    assign tick  = ctrl[0] & (count != '0) & ~ld_wr;
    assign fire  = tick & (count == 32'd1);

    assign rmux = idx == 4'd0 ? ID_VAL :
                  idx == 4'd1 ? {29'd0, ctrl} :
                  idx == 4'd2 ? load :
                  idx == 4'd3 ? count :
                  idx == 4'd4 ? {31'd0, expd} : scratch;
    assign bus.hrdata = done & ~wr ? rmux : '0;

`ifdef EVA_AHB_WAIT_EN
    logic [2:0] wcnt;
`endif

    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            state          <= IDLE;
            bus.hready_out <= 1'b1;
            bus.hresp      <= 2'b00;
            wr             <= 1'b0;
            idx            <= '0;
`ifdef EVA_AHB_WAIT_EN
            wcnt           <= '0;
`endif
        end else if (acc) begin
            state     <= bad ? ERR1 : DATA;
            wr        <= bus.hwrite;
            idx       <= bus.haddr[5:2];
            bus.hresp <= {1'b0, bad};
`ifdef EVA_AHB_WAIT_EN
            wcnt           <= 3'(WAIT_CYC);
            bus.hready_out <= ~bad & (WAIT_CYC == 0);
`else
            bus.hready_out <= ~bad;
`endif
        end else if (state == ERR1) begin
            state          <= ERR2;
            bus.hready_out <= 1'b1;
`ifdef EVA_AHB_WAIT_EN
        end else if (state == DATA && !bus.hready_out) begin
            wcnt           <= wcnt - 3'd1;
            bus.hready_out <= wcnt == 3'd1;
`endif
        end else begin
            state          <= IDLE;
            bus.hready_out <= 1'b1;
            bus.hresp      <= 2'b00;
        end
    end

    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expd    <= 1'b0;
            scratch <= '0;
            intr    <= 1'b0;
        end else begin
            if (done & wr & idx == 4'd1) ctrl <= bus.hwdata[2:0];
            if (ld_wr) load <= bus.hwdata;
            if (done & wr & idx == 4'd5) scratch <= bus.hwdata;
            count <= ld_wr ? bus.hwdata : fire ? (ctrl[1] ? load : '0) : tick ? count - 32'd1 : count;
            // Expiry set beats a simultaneous W1C
            expd  <= fire | (expd & ~w1c);
            intr  <= expd & ctrl[2];
        end
    end
endmodule
